hpp_frame_scheduler: RTL
========================

# hpp_frame_scheduler

Sequences HPP automaton generation updates into the VGA vertical blanking interval. The block waits for the driver's one-cycle `enter_v_front` pulse, then issues a programmable number of start/done handshakes to the update engine. After each completed generation it flips the ping-pong grid buffer select, so the pixel fetch path never sees a half-updated grid. It also tracks a generation count, supports single-step while paused, and flags overruns and engine timeouts.

## Interface
- `TIMEOUT`, default 32000: maximum cycles spent waiting for `upd_done` after one `upd_start` before the step is aborted.
- `GEN_W`, default 16: width of `gen_count`.
- `clock` input 1: 25 MHz pixel clock, shared with the VGA driver.
- `reset` input 1: synchronous, active-high.
- `enter_v_front` input 1: one-cycle pulse from the VGA driver marking the start of the vertical front porch.
- `run` input 1: level. 1 = free-run `steps_per_frame` generations per frame; 0 = paused.
- `step_req` input 1: one-cycle pulse requesting one generation while paused.
- `steps_per_frame` input 4: generations per frame in run mode. 0 = no updates.
- `clear_err` input 1: pulse that clears the sticky error flags.
- `upd_done` input 1: one-cycle pulse from the update engine when a generation has been fully written.
- `upd_start` output 1: one-cycle pulse that starts one generation.
- `buf_sel` output 1: buffer read by the VGA pixel fetch and by the engine. The engine writes `~buf_sel`.
- `busy` output 1: high in every state except IDLE.
- `gen_count` output GEN_W: count of completed generations; wraps modulo 2^GEN_W.
- `overrun` output 1: sticky; `enter_v_front` arrived while busy.
- `timeout_err` output 1: sticky; the engine failed to answer within TIMEOUT.

## Operation
- Reset values:
  - State: IDLE.
  - `upd_start`, `busy`, `buf_sel`, `overrun`, `timeout_err`: 0.
  - `gen_count`: 0; internal `remaining`, `pending_step`, and timeout counter: 0.
- `pending_step` register:
  - Set by `step_req` in any state.
  - Cleared when it is consumed.
- States and transitions:
  - IDLE, on `enter_v_front`:
    - If `run`=1 and `steps_per_frame`≠0: load `remaining` = `steps_per_frame` and go to START.
    - Else if `run`=0 and (`pending_step` or `step_req` this cycle): load `remaining` = 1, clear `pending_step`, go to START.
    - Otherwise stay in IDLE.
  - START: assert `upd_start` for this cycle only, clear the timeout counter, go to WAIT.
  - WAIT, on `upd_done`:
    - Toggle `buf_sel`, increment `gen_count`, decrement `remaining`.
    - If `remaining` was 1, go to IDLE; else go to START.
  - WAIT, no `upd_done`: increment the timeout counter. When it reaches TIMEOUT-1:
    - Set `timeout_err`, go to IDLE.
    - Do not toggle `buf_sel`; keep `gen_count` unchanged; discard `remaining`.
- `upd_done` outside WAIT is ignored.
- `enter_v_front` outside IDLE sets `overrun` and is otherwise ignored: no restart, `remaining` unchanged.
- Changes to `run` or `steps_per_frame` mid-frame have no effect until the next IDLE sampling.
- Reset mid-operation aborts immediately to the reset values. No `upd_start` is issued in the cycle after reset.

## Timing
- `enter_v_front` in cycle T (state IDLE) → START in T+1 → `upd_start`=1 in T+1 only; state is WAIT from T+2.
- `upd_done` in cycle D (state WAIT):
  - `buf_sel` and `gen_count` update in D+1.
  - If steps remain, the next `upd_start` is in D+1 (one-cycle turnaround).
- `busy` rises in T+1. It falls the cycle after the final `upd_done` or after the timeout.
- Simultaneous events:
  - `upd_done` on the timeout cycle counts as done; no error is raised.
  - `clear_err` together with a new error event: the set wins.
  - `step_req` together with `enter_v_front` in IDLE with `run`=0: the step is taken.
  - `step_req` with `run`=1: it stays pending until a paused frame consumes it.
- `gen_count` wraps from 2^GEN_W−1 to 0 with no flag.

## Test plan
- Run mode: `run`=1, `steps_per_frame`=3, engine answers `upd_done` 10 cycles after each start, one `enter_v_front` pulse → exactly 3 `upd_start` pulses; `buf_sel` toggles 0→1→0→1; `gen_count`=3; `busy` drops one cycle after the third done.
- Paused mode: `run`=0, one `step_req` pulse, then two `enter_v_front` pulses → one generation on the first frame, none on the second; `gen_count`=1.
- Timeout: TIMEOUT=50, engine never answers → `timeout_err`=1 after 50 WAIT cycles; `buf_sel` unchanged; `gen_count` unchanged; back in IDLE. `clear_err` then clears the flag.
- Overrun: `steps_per_frame`=2, `enter_v_front` pulsed while in WAIT → `overrun`=1; still exactly 2 generations completed.
- Reset mid-WAIT with `buf_sel`=1 → every output returns to 0 in the next cycle. An `upd_done` arriving afterwards is ignored.
- Wrap: GEN_W=4, 17 single-step generations → `gen_count`=1; `steps_per_frame`=0 with `run`=1 → no `upd_start` pulses.

Source files
------------

// File: rtl/hpp_frame_scheduler.sv
// Vertical-blanking scheduler for HPP generation updates: issues start/done
// handshakes to the update engine and flips the ping-pong grid buffer per generation.
module hpp_frame_scheduler #(
  parameter int TIMEOUT = 32000,
  parameter int GEN_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter_v_front,
  input  logic             run,
  input  logic             step_req,
  input  logic [3:0]       steps_per_frame,
  input  logic             clear_err,
  input  logic             upd_done,
  output logic             upd_start,
  output logic             buf_sel,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             pending_q, pending_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             buf_sel_q, buf_sel_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             upd_start_q, upd_start_d;
  logic             busy_q, busy_d;
  logic             pending_clr;
  logic             tmo_set;
  logic             ovr_set;

  // Next-state, handshake sequencing and sticky error flag logic
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tmo_d       = tmo_q;
    buf_sel_d   = buf_sel_q;
    gen_d       = gen_q;
    pending_clr = 1'b0;
    tmo_set     = 1'b0;
    ovr_set     = enter_v_front && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (enter_v_front) begin
          if (run && (steps_per_frame != 4'd0)) begin
            remaining_d = steps_per_frame;
            state_d     = S_START;
          end else if (!run && (pending_q || step_req)) begin
            remaining_d = 4'd1;
            pending_clr = 1'b1;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final timeout cycle still counts as a completed generation
        if (upd_done) begin
          buf_sel_d   = ~buf_sel_q;
          gen_d       = gen_q + GEN_W'(1);
          remaining_d = remaining_q - 4'd1;
          state_d     = (remaining_q == 4'd1) ? S_IDLE : S_START;
        end else if (tmo_q == TMO_LAST) begin
          tmo_set     = 1'b1;
          remaining_d = 4'd0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d   = (pending_q || step_req) && !pending_clr;
    overrun_d   = ovr_set ? 1'b1 : (clear_err ? 1'b0 : overrun_q);
    timeout_d   = tmo_set ? 1'b1 : (clear_err ? 1'b0 : timeout_q);
    upd_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 4'd0;
      pending_q   <= 1'b0;
      tmo_q       <= '0;
      buf_sel_q   <= 1'b0;
      gen_q       <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      upd_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      tmo_q       <= tmo_d;
      buf_sel_q   <= buf_sel_d;
      gen_q       <= gen_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      upd_start_q <= upd_start_d;
      busy_q      <= busy_d;
    end
  end

  assign upd_start   = upd_start_q;
  assign buf_sel     = buf_sel_q;
  assign busy        = busy_q;
  assign gen_count   = gen_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
